// File: rtl/buffer_sched_pkg.sv
// Shared definitions for the adding-buffer scheduler.
//   - sched_state_e : controller FSM encoding (RUN = 0, DRAIN = 1)
//   - rr_pick       : one-hot round-robin select, generic up to MaxReq requesters
package buffer_sched_pkg;

  localparam int unsigned MaxReq  = 32;
  localparam int unsigned MaxReqW = 5;

  typedef enum logic {
    StRun   = 1'b0,
    StDrain = 1'b1
  } sched_state_e;

  // Return a one-hot vector selecting the first set bit of req at or after ptr,
  // wrapping at nreq. Only the low nreq bits of req are considered.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                input int unsigned       ptr,
                                                input int unsigned       nreq);
    logic [MaxReq-1:0] gnt;
    logic              found;
    int unsigned       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < nreq && !found) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx[MaxReqW-1:0]]) begin
          gnt[idx[MaxReqW-1:0]] = 1'b1;
          found                 = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/buffer_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr.
// Ports:
//   req   in  NREQ  request vector (already qualified by the caller)
//   ptr   in  PW    priority pointer, 0..NREQ-1
//   grant out NREQ  one-hot grant, all zero when no request
module rr_arbiter
  import buffer_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [MaxReq-1:0] req_ext;
  logic [MaxReq-1:0] gnt_ext;
  logic              unused_gnt_hi;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    gnt_ext             = rr_pick(req_ext, 32'(ptr), NREQ);
  end

  assign grant = gnt_ext[NREQ-1:0];

  // Upper bits are always zero for a legal NREQ; folded here only to keep them referenced.
  assign unused_gnt_hi = ^gnt_ext;

endmodule

// File: rtl/buffer_sched.sv
// Scheduler for the adding buffer (adder + FIFO).
// Shares the buffer write port among NREQ requesters by round-robin and drains the
// read port into a registered valid/ready stream through a 2-entry skid queue.
// FIFO occupancy is tracked locally so the FIFO flags are never needed.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   req_valid/a/b         requester operand pairs (slice i = requester i)
//   req_ready             one-hot accept, combinational
//   buf_in0/1, buf_in_en  registered write to the buffer
//   buf_out_en, buf_out   registered read request, data returns one cycle later
//   m_valid/m_data/m_ready output stream of sums
//   flush, flush_done     level-sensitive drain request, completion pulse
//   level                 committed FIFO occupancy
module buffer_sched
  import buffer_sched_pkg::*;
#(
  parameter  int unsigned N     = 32,
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      buf_in0,
  output logic [N-1:0]      buf_in1,
  output logic              buf_in_en,
  output logic              buf_out_en,
  input  logic [N-1:0]      buf_out,
  output logic              m_valid,
  output logic [N-1:0]      m_data,
  input  logic              m_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic [LW-1:0]     level
);

  localparam int unsigned  PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LW:0]  DepthL = (LW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sched_state_e  state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  in0_q, in1_q;
  logic          in_en_q;
  logic          out_en_q, out_en_d;
  logic          rd_pend_q;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    skid_cnt_q, skid_cnt_d;
  logic [N-1:0]  skid0_q, skid0_d;
  logic [N-1:0]  skid1_q, skid1_d;

  // ---------------------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------------------
  logic [LW:0]     lvl_wr;
  logic            wr_allow;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic            gnt_any;
  logic [PW-1:0]   win_idx;
  logic [N-1:0]    win_a, win_b;

  // A write already in flight is counted, reads are not: admission stays conservative.
  assign lvl_wr = {1'b0, level_q} + {{LW{1'b0}}, in_en_q};
  // rst gates grants so req_ready reads zero while reset is held.
  assign wr_allow = rst && (state_q == StRun) && (lvl_wr < DepthL);
  assign arb_req  = req_valid & {NREQ{wr_allow}};

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign req_ready = grant;
  assign gnt_any   = |grant;

  always_comb begin
    win_idx = '0;
    win_a   = '0;
    win_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_idx = PW'(i);
        win_a   = req_a[i*N +: N];
        win_b   = req_b[i*N +: N];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Level counter
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    case ({in_en_q, out_en_q})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read side: request issue and skid queue
  // ---------------------------------------------------------------------------
  logic       pop;
  logic       lvl_ok;
  logic       room_ok;
  logic [2:0] rd_occ;

  assign pop = (skid_cnt_q != 2'd0) && m_ready;

  // A read in its issue cycle has already claimed one FIFO entry.
  assign lvl_ok = level_q > {{(LW-1){1'b0}}, out_en_q};

  // Words in the skid plus words still travelling from the FIFO must fit in two slots
  // after this cycle's pop; comparing against 2 + pop avoids a negative term.
  assign rd_occ  = {1'b0, skid_cnt_q} + {2'b00, rd_pend_q} + {2'b00, out_en_q};
  assign room_ok = rd_occ < (3'd2 + {2'b00, pop});

  assign out_en_d = lvl_ok && room_ok;

  // Head stays put unless popped, so m_data is stable under back-pressure.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    if (pop) begin
      skid0_d    = skid1_q;
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
    if (rd_pend_q) begin
      if (skid_cnt_d == 2'd0) begin
        skid0_d = buf_out;
      end else begin
        skid1_d = buf_out;
      end
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  logic drain_empty;

  assign drain_empty = (level_q == '0) && !rd_pend_q && (skid_cnt_q == 2'd0);

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      StRun: begin
        if (flush) state_d = StDrain;
      end
      StDrain: begin
        if (drain_empty) begin
          state_d    = StRun;
          flush_done = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      ptr_q      <= '0;
      in0_q      <= '0;
      in1_q      <= '0;
      in_en_q    <= 1'b0;
      out_en_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      level_q    <= '0;
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      in_en_q    <= gnt_any;
      if (gnt_any) begin
        in0_q <= win_a;
        in1_q <= win_b;
      end
      out_en_q   <= out_en_d;
      rd_pend_q  <= out_en_q;
      level_q    <= level_d;
      skid_cnt_q <= skid_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

  assign buf_in0    = in0_q;
  assign buf_in1    = in1_q;
  assign buf_in_en  = in_en_q;
  assign buf_out_en = out_en_q;
  assign m_valid    = (skid_cnt_q != 2'd0);
  assign m_data     = skid0_q;
  assign level      = level_q;

endmodule

// File: tb/tb_buffer_sched.sv
// Bench for buffer_sched: includes a behavioural model of the adding buffer itself
// (sum then FIFO, output one cycle after out_en) and a transaction-level model of the
// scheduler rules, checked every cycle, plus directed literal expectations.
module tb_buffer_sched;

  localparam int unsigned N     = 32;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      buf_in0, buf_in1;
  logic              buf_in_en, buf_out_en;
  logic [N-1:0]      buf_out = '0;
  logic              m_valid;
  logic [N-1:0]      m_data;
  logic              m_ready = 1'b1;
  logic              flush = 1'b0;
  logic              flush_done;
  logic [LW-1:0]     level;

  always #5 clk = ~clk;

  buffer_sched #(
    .N     (N),
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .buf_in0    (buf_in0),
    .buf_in1    (buf_in1),
    .buf_in_en  (buf_in_en),
    .buf_out_en (buf_out_en),
    .buf_out    (buf_out),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .level      (level)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Adding buffer: stores in0+in1 on in_en, presents the oldest sum one cycle after out_en.
  // ---------------------------------------------------------------------------
  logic [N-1:0] fifo_q[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fifo_q.delete();
        buf_out <= '0;
      end else begin
        if (buf_out_en && fifo_q.size() > 0) buf_out <= fifo_q.pop_front();
        if (buf_in_en) fifo_q.push_back(buf_in0 + buf_in1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler model: grant order queue, occupancy by counting, drain by word balance.
  // ---------------------------------------------------------------------------
  int           m_ptr    = 0;
  bit           m_drain  = 0;
  bit           m_in_en  = 0;
  logic [N-1:0] m_in0    = '0;
  logic [N-1:0] m_in1    = '0;
  int           m_lvl    = 0;
  int           m_commit = 0;
  int           m_pops   = 0;
  logic [N-1:0] exp_q[$];

  function automatic int pick();
    if (m_drain || (m_lvl + (m_in_en ? 1 : 0)) >= DEPTH) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ptr = 0; m_drain = 0; m_in_en = 0; m_in0 = '0; m_in1 = '0;
        m_lvl = 0; m_commit = 0; m_pops = 0;
        exp_q.delete();
      end else begin
        int g;
        int occ;
        g   = pick();
        occ = m_commit - m_pops;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("pop_without_grant", 64'(m_data), 64'hDEAD);
          else chk("m_data_order", 64'(m_data), 64'(exp_q.pop_front()));
          m_pops++;
        end
        if (buf_out_en) m_lvl--;
        if (m_in_en) begin
          m_lvl++;
          m_commit++;
        end
        if (!m_drain && flush) m_drain = 1;
        else if (m_drain && occ == 0) m_drain = 0;
        if (g >= 0) begin
          m_in_en = 1;
          m_in0   = req_a[g*N +: N];
          m_in1   = req_b[g*N +: N];
          exp_q.push_back(m_in0 + m_in1);
          m_ptr   = (g + 1) % NREQ;
        end else begin
          m_in_en = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int g;
        logic [NREQ-1:0] exp_rr;
        g      = pick();
        exp_rr = '0;
        if (g >= 0) exp_rr[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("buf_in_en", 64'(buf_in_en), 64'(m_in_en));
        chk("buf_in0", 64'(buf_in0), 64'(m_in0));
        chk("buf_in1", 64'(buf_in1), 64'(m_in1));
        chk("level", 64'(level), 64'(m_lvl));
        chk("flush_done", 64'(flush_done), 64'(m_drain && (m_commit - m_pops == 0)));
        if (buf_out_en) chk("read_from_empty", 64'(m_lvl > 0), 64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    m_ready   = 1'b1;
    flush     = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_mvalid(input string name, input int limit);
    bit ok;
    ok = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  initial begin
    logic [NREQ-1:0] exp_seq[5];
    logic [NREQ-1:0] got_seq[5];
    int ng, cnt, oe_cnt, pop_cnt, fd_cnt;
    bit ok;

    // Reset state, with requests present to prove req_ready is held low.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_buf_in_en", 64'(buf_in_en), 64'd0);
    chk("rst_buf_out_en", 64'(buf_out_en), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);

    // Single requester 1: 5 + 7.
    do_reset();
    set_pair(1, 32'd5, 32'd7);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    wait_mvalid("t1_mvalid_timeout", 10);
    chk("t1_sum", 64'(m_data), 64'd12);
    repeat (6) step();
    @(negedge clk);
    chk("t1_level_back", 64'(level), 64'd0);
    chk("t1_idle", 64'(m_valid), 64'd0);

    // All four requesters held: rotation from pointer 0.
    do_reset();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < NREQ; i++) set_pair(i, 32'h100 * (i + 1), 32'(i));
    req_valid = 4'hF;
    ng = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (c < 5) got_seq[c] = req_ready;
      if (|req_ready) ng++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) set_pair(i, 32'(c * 16 + i), 32'(i * 3 + 1));
    end
    for (int k = 0; k < 5; k++) chk("t2_rotation", 64'(got_seq[k]), 64'(exp_seq[k]));
    req_valid = '0;
    repeat (60) step();
    chk("t2_all_words_out", 64'(m_pops), 64'(ng));
    chk("t2_level_empty", 64'(level), 64'd0);

    // Back-pressure: saturate the FIFO, then release.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_pair(i, 32'(i + 1), 32'h10);
    m_ready   = 1'b0;
    req_valid = 4'hF;
    ok = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (level == LW'(DEPTH)) begin
        ok = 1;
        break;
      end
    end
    chk("t3_saturate_timeout", 64'(ok), 64'd1);
    repeat (3) step();
    @(negedge clk);
    chk("t3_level_16", 64'(level), 64'd16);
    chk("t3_no_grant", 64'(req_ready), 64'd0);
    chk("t3_m_valid", 64'(m_valid), 64'd1);
    step();
    req_valid = '0;
    m_ready   = 1'b1;
    cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (m_valid && m_ready) cnt++;
    end
    chk("t3_words_out", 64'(cnt), 64'd18);

    // Carry is dropped.
    do_reset();
    set_pair(2, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    wait_mvalid("t4_mvalid_timeout", 10);
    chk("t4_wrap_sum", 64'(m_data), 64'd1);
    repeat (6) step();

    // Flush with 12 words held (10 in the FIFO, 2 in the skid).
    do_reset();
    set_pair(0, 32'd100, 32'd1);
    m_ready   = 1'b0;
    req_valid = 4'b0001;
    ng = 0;
    for (int n = 0; n < 40 && ng < 12; n++) begin
      @(negedge clk);
      if (req_ready[0]) ng++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (8) step();
    @(negedge clk);
    chk("t5_level_10", 64'(level), 64'd10);
    chk("t5_skid_held", 64'(m_valid), 64'd1);
    step();
    flush   = 1'b1;
    m_ready = 1'b1;
    oe_cnt = 0; pop_cnt = 0; fd_cnt = 0; ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (buf_out_en) oe_cnt++;
      if (m_valid && m_ready) pop_cnt++;
      if (flush_done) begin
        fd_cnt++;
        ok = 1;
      end
      @(posedge clk);
      #1;
      if (ok) begin
        flush = 1'b0;
        break;
      end
      if (n == 1) req_valid = 4'hF;
      if (n == 6) req_valid = '0;
    end
    chk("t5_drain_timeout", 64'(ok), 64'd1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (flush_done) fd_cnt++;
    end
    chk("t5_fifo_reads", 64'(oe_cnt), 64'd10);
    chk("t5_words_out", 64'(pop_cnt), 64'd12);
    chk("t5_single_pulse", 64'(fd_cnt), 64'd1);
    step();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t5_run_again", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    repeat (10) step();

    // Asynchronous reset mid-operation.
    do_reset();
    set_pair(3, 32'd9, 32'd9);
    m_ready   = 1'b0;
    req_valid = 4'b1000;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (level == LW'(5)) begin
        ok = 1;
        break;
      end
    end
    chk("t6_level5_timeout", 64'(ok), 64'd1);
    chk("t6_m_valid_before", 64'(m_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req_ready", 64'(req_ready), 64'd0);
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t6_rst_m_data", 64'(m_data), 64'd0);
    chk("t6_rst_buf_in_en", 64'(buf_in_en), 64'd0);
    chk("t6_rst_buf_out_en", 64'(buf_out_en), 64'd0);
    chk("t6_rst_buf_in0", 64'(buf_in0), 64'd0);
    req_valid = 4'hF;
    m_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_level_after", 64'(level), 64'd0);
    chk("t6_first_grant", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    repeat (40) step();
    chk("final_all_delivered", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
